uwu_tx_arbiter: RTL

//   Shares the single UART transmit byte port of the uwuifier between NUM_REQ byte-stream sources.

---
 rtl/uwu_tx_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/uwu_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing the uwuifier UART TX byte port between NUM_REQ sources.
// Optional owner-idle forced release is enabled by defining UWU_ARB_TIMEOUT_EN.
module uwu_tx_arbiter #(
   parameter int unsigned NUM_REQ        = 2,
   parameter int unsigned DATA_W         = 8,
   parameter int unsigned TIMEOUT_CYCLES = 2080
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      tx_valid,
   output logic [DATA_W-1:0]         tx_data,
   input  logic                      tx_ready,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      timeout
);

   localparam int unsigned PTR_W = $clog2(NUM_REQ);

   typedef enum logic {
      IDLE,
      LOCKED
   } state_e;

   state_e               state_q, state_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [PTR_W-1:0]     owner_q, owner_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;

   logic                 pick_found;
   logic [PTR_W-1:0]     pick_idx;
   int unsigned          cand;

   logic                 locked;
   logic                 own_valid;
   logic                 own_last;
   logic [DATA_W-1:0]    own_data;
   logic                 xfer;
   logic                 force_rel;

   // Search starts one past the last owner and wraps; NUM_REQ need not be a power of two.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = 32'(ptr_q) + 32'd1 + i;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (!pick_found && req_valid[PTR_W'(cand)]) begin
            pick_found = 1'b1;
            pick_idx   = PTR_W'(cand);
         end
      end
   end

   always_comb begin
      own_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (owner_q == PTR_W'(i)) begin
            own_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign locked    = (state_q == LOCKED);
   assign own_valid = req_valid[owner_q];
   assign own_last  = req_last[owner_q];

   assign tx_valid  = locked & own_valid;
   assign tx_data   = tx_valid ? own_data : '0;
   assign req_ready = locked ? (grant_q & {NUM_REQ{tx_ready}}) : '0;
   assign grant     = grant_q;
   assign xfer      = tx_valid & tx_ready;

`ifdef UWU_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             expired;

   assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES));

   // A transfer in the expiry cycle wins: the counter clears and the owner keeps the port.
   always_comb begin
      cnt_d = cnt_q;
      if (!locked || xfer) begin
         cnt_d = '0;
      end else if (!expired) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign force_rel = locked & ~xfer & expired;
   assign timeout   = force_rel;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign force_rel = 1'b0;
   assign timeout   = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      grant_d = grant_q;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d           = LOCKED;
               owner_d           = pick_idx;
               grant_d           = '0;
               grant_d[pick_idx] = 1'b1;
            end
         end
         LOCKED: begin
            if ((xfer && own_last) || force_rel) begin
               state_d = IDLE;
               ptr_d   = owner_q;
               grant_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // Pointer resets to the last source so the first search begins at source 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= PTR_W'(NUM_REQ - 1);
         owner_q <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         grant_q <= grant_d;
      end
   end

endmodule
